// File: rtl/riscv_multicycle_controller.sv
// Moore-style sequencer for the shared-memory multicycle RV32I datapath.
// Optional RV_ILLEGAL_TRAP_EN makes the ILLEGAL state a sink that raises illegal_op until reset.
module riscv_multicycle_controller #(
  parameter int unsigned ALU_W = 3,
  parameter int unsigned IMM_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [IMM_W-1:0] imm_src,
  output logic             instr_done,
  output logic             illegal_op
);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4);

  localparam logic [IMM_W-1:0] IMM_I = IMM_W'(0);
  localparam logic [IMM_W-1:0] IMM_S = IMM_W'(1);
  localparam logic [IMM_W-1:0] IMM_B = IMM_W'(2);
  localparam logic [IMM_W-1:0] IMM_J = IMM_W'(3);
  localparam logic [IMM_W-1:0] IMM_U = IMM_W'(4);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LINK,
    S_LUI, S_ILLEGAL
  } state_t;

  state_t           state, state_next;
  logic [ALU_W-1:0] arith_op;
  logic             arith_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Shared R/I arithmetic decode; funct7_5 selects SUB only for R-type.
  always_comb begin
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (funct3)
      3'b000:  arith_op = (funct7_5 && state == S_EXEC_R) ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b010:  arith_op = ALU_SLT;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm_src    = IMM_I;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW:   begin imm_src = IMM_I; state_next = S_MEM_ADR; end
          OP_SW:   begin imm_src = IMM_S; state_next = S_MEM_ADR; end
          OP_R:    state_next = S_EXEC_R;
          OP_I:    state_next = S_EXEC_I;
          OP_B:    begin imm_src = IMM_B; state_next = S_BRANCH; end
          OP_JAL:  begin imm_src = IMM_J; state_next = S_JAL; end
          OP_JALR: state_next = S_JALR;
          OP_LUI:  begin imm_src = IMM_U; state_next = S_LUI; end
          default: state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = 1'b1;
        state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = arith_op;
        state_next = arith_ok ? S_ALU_WB : S_ILLEGAL;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_ctrl   = arith_op;
        state_next = arith_ok ? S_ALU_WB : S_ILLEGAL;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // ALUOut already holds the branch target computed during DECODE.
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        instr_done = 1'b1;
        case (funct3)
          3'b000:  begin alu_ctrl = ALU_SUB; pc_write = zero;  end
          3'b001:  begin alu_ctrl = ALU_SUB; pc_write = ~zero; end
          3'b100:  begin alu_ctrl = ALU_SLT; pc_write = ~zero; end
          3'b101:  begin alu_ctrl = ALU_SLT; pc_write = zero;  end
          default: begin instr_done = 1'b0; state_next = S_ILLEGAL; end
        endcase
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_next = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef RV_ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
        state_next = S_ILLEGAL;
`else
        instr_done = 1'b1;
`endif
      end
      default: state_next = S_FETCH;
    endcase

    // Reset holds the FETCH datapath selects but blocks every write.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors are queued per instruction and compared each cycle.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_ctrl, imm_src;
  logic       instr_done, illegal_op;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [18:0] exp_q[$];

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, SLT = 3'd4;
  localparam logic [2:0] II = 3'd0, IS = 3'd1, IB = 3'd2, IJ = 3'd3, IU = 3'd4;

  riscv_multicycle_controller #(.ALU_W(3), .IMM_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .imm_src(imm_src), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ev(input logic pcw, input logic adr, input logic memw,
                                     input logic irw, input logic regw, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [2:0] imm,
                                     input logic done, input logic ill);
    return {pcw, adr, memw, irw, regw, res, a, b, alu, imm, done, ill};
  endfunction

  function automatic logic [18:0] obs();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_ctrl, imm_src, instr_done, illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic z);
    opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
  endtask

  task automatic push_fetch_decode(input logic [2:0] imm);
    exp_q.push_back(ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, imm, 0, 0));
  endtask

  // Called at a negedge; drains the queue one cycle per entry, ending on the next negedge.
  task automatic drain(input string name);
    int cyc = 1;
    while (exp_q.size() > 0) begin
      #1;
      check($sformatf("%s_c%0d", name, cyc), 32'(obs()), 32'(exp_q.pop_front()));
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset(input string name);
    #1;
    check(name, 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, II, 0, 0)));
  endtask

  task automatic run_r(input string name, input logic [2:0] f3, input logic f75, input logic [2:0] alu);
    set_ir(7'b0110011, f3, f75, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain(name);
  endtask

  task automatic run_br(input string name, input logic [2:0] f3, input logic z,
                        input logic [2:0] alu, input logic pcw);
    set_ir(7'b1100011, f3, 1'b0, z);
    push_fetch_decode(IB);
    exp_q.push_back(ev(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, II, 1, 0));
    drain(name);
  endtask

  task automatic run_lui(input string name);
    set_ir(7'b0110111, 3'b000, 1'b0, 1'b0);
    push_fetch_decode(IU);
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, ADD, IU, 1, 0));
    drain(name);
  endtask

  initial begin
    rst = 1'b1;
    set_ir(7'b0000000, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_vec");
    @(negedge clk);
    rst = 1'b0;

    // LW x5,8(x1)
    set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("lw");

    // SW
    set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
    push_fetch_decode(IS);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, IS, 0, 0));
    exp_q.push_back(ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("sw");

    run_r("r_add", 3'b000, 1'b0, ADD);
    run_r("r_sub", 3'b000, 1'b1, SUB);
    run_r("r_and", 3'b111, 1'b0, AND_);
    run_r("r_or",  3'b110, 1'b0, OR_);
    run_r("r_slt", 3'b010, 1'b0, SLT);

    // I-type ADDI with funct7_5 set must stay ADD
    set_ir(7'b0010011, 3'b000, 1'b1, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("addi");

    run_br("beq_t",  3'b000, 1'b1, SUB, 1'b1);
    run_br("beq_nt", 3'b000, 1'b0, SUB, 1'b0);
    run_br("bne_t",  3'b001, 1'b0, SUB, 1'b1);
    run_br("blt_nt", 3'b100, 1'b1, SLT, 1'b0);
    run_br("bge_t",  3'b101, 1'b1, SLT, 1'b1);

    // JAL
    set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
    push_fetch_decode(IJ);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("jal");

    // JALR
    set_ir(7'b1100111, 3'b000, 1'b0, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, ADD, II, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, ADD, II, 1, 0));
    drain("jalr");

    run_lui("lui");

    // Reset pulse during MEM_READ of a load
    set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, II, 0, 0));
    drain("lw_abort");
    rst = 1'b1;
    check_reset("abort_rst");
    @(negedge clk);
    check_reset("abort_rst_hold");
    @(negedge clk);
    rst = 1'b0;
    run_lui("after_abort");

    // Illegal R-type funct3 (001)
    set_ir(7'b0110011, 3'b001, 1'b0, 1'b0);
    push_fetch_decode(II);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ADD, II, 0, 0));
`ifdef RV_ILLEGAL_TRAP_EN
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 0, 1));
    drain("r_bad");
    rst = 1'b1;
    check_reset("r_bad_rst");
    @(negedge clk);
    rst = 1'b0;
`else
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("r_bad");
`endif

    // Unknown opcode 1111111
    set_ir(7'b1111111, 3'b000, 1'b0, 1'b0);
    push_fetch_decode(II);
`ifdef RV_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 0, 1));
    drain("trap");
    rst = 1'b1;
    check_reset("trap_rst");
    @(negedge clk);
    rst = 1'b0;
`else
    exp_q.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, II, 1, 0));
    drain("ill_nop");
`endif
    run_lui("after_ill");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Moore FSM that sequences the team's multicycle RV32I datapath, which shares one memory, one ALU and registered IR/OldPC/A/B/ALUOut/Data.
- Each cycle it drives the mux selects, write enables, ALU op and immediate format.
- Inputs come from IR fields plus the ALU zero flag; IR is stable from DECODE until the next FETCH.

Parameters:
- ALU_W, 3, width of alu_ctrl: ADD=000, SUB=001, AND=010, OR=011, SLT=100.
- IMM_W, 3, width of imm_src: I=000, S=001, B=010, J=011, U=100.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  combinational ALU zero flag
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_write  out  1  data store enable
- ir_write  out  1  IR and OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALU direct, 11=imm
- alu_src_a  out  2  00=PC, 01=OldPC, 10=A
- alu_src_b  out  2  00=B, 01=imm, 10=const 4
- alu_ctrl  out  ALU_W  ALU operation
- imm_src  out  IMM_W  immediate format
- instr_done  out  1  high in the final cycle of each instruction
- illegal_op  out  1  see Optional Feature

Behaviour:
- Reset:
  - State is FETCH.
  - While rst=1, pc_write, ir_write, reg_write, mem_write, instr_done and illegal_op are forced to 0.
  - All other outputs equal their FETCH values.
- Outputs are decoded from state, plus opcode/funct3/funct7_5/zero where noted below. Unlisted outputs are 0.
- Opcodes: LW 0000011, SW 0100011, R 0110011, I 0010011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- FETCH: adr_src=0, ir_write=1, a=PC, b=4, ADD, result_src=10, pc_write=1. Next state DECODE.
- DECODE: a=OldPC, b=imm, ADD, imm_src from opcode. Next state:
  - LW/SW -> MEM_ADR
  - R -> EXEC_R
  - I -> EXEC_I
  - B -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> LUI
  - else -> ILLEGAL
- MEM_ADR: a=A, b=imm, ADD, imm_src I (LW) or S (SW). Next state MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: adr_src=1. Next state MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next state FETCH.
- MEM_WRITE: adr_src=1, mem_write=1. Next state FETCH.
- EXEC_R: a=A, b=B. Next state ALU_WB. alu_ctrl from {funct3, funct7_5}:
  - 000/0=ADD, 000/1=SUB
  - 111=AND, 110=OR, 010=SLT
  - other -> ILLEGAL (no ALU_WB)
- EXEC_I: a=A, b=imm, imm_src I. Next state ALU_WB. alu_ctrl from funct3 (same map, funct7_5 ignored); other -> ILLEGAL.
- ALU_WB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH: a=A, b=B, result_src=00 (ALUOut holds target from DECODE). Next state FETCH.
  - beq 000: SUB, pc_write=zero
  - bne 001: SUB, pc_write=~zero
  - blt 100: SLT, pc_write=~zero
  - bge 101: SLT, pc_write=zero
  - other funct3: no pc_write, treated as ILLEGAL
- JAL: a=OldPC, b=4, ADD, result_src=00, pc_write=1. Next state ALU_WB.
- JALR: a=A, b=imm, imm_src I, ADD, result_src=10, pc_write=1. Next state LINK.
- LINK: a=OldPC, b=4, ADD, result_src=10, reg_write=1. Next state FETCH.
- LUI: imm_src U, result_src=11, reg_write=1. Next state FETCH.
- instr_done=1 in every state whose next state is FETCH.
- Latencies in cycles: LW 5, SW 4, R/I 4, B 3, JAL 4, JALR 4, LUI 3.
- Reset asserted mid-instruction aborts it; no further writes occur and the FSM restarts at FETCH when rst falls.
- Unreachable state encodings recover to FETCH.

Optional Feature:
- Macro RV_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is a sink state. illegal_op=1 and all enables are 0 until rst.
- Undefined: ILLEGAL behaves as a NOP for one cycle (instr_done=1, no writes), then goes to FETCH. illegal_op is tied to 0.

Test Plan:
- Reset, then LW x5,8(x1): states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB. reg_write=1 with result_src=01 only in cycle 5; instr_done=1 in cycle 5 only.
- SW: mem_write=1 with adr_src=1 in cycle 4 only; reg_write stays 0 throughout.
- R-type SUB (funct7_5=1, funct3=000): alu_ctrl=001 in EXEC_R. AND: alu_ctrl=010. SLT: alu_ctrl=100.
- BEQ with zero=1 gives pc_write=1 in cycle 3; zero=0 gives pc_write=0. BGE with zero=1 gives alu_ctrl=100 and pc_write=1.
- JALR: cycle 3 pc_write=1 with result_src=10; cycle 4 reg_write=1 with alu_src_a=01, alu_src_b=10.
- Opcode 1111111:
  - With trap: illegal_op=1 held for 20 cycles with no enables; rst returns to FETCH.
  - Without trap: FETCH again in cycle 4.
  - rst pulse during MEM_READ: no reg_write, restart in FETCH.
